// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the I-cache miss path and the D-cache miss/writeback path.
// D side has fixed priority; I side wins a contested arbitration after STARVE_LIMIT contested D grants.
module mem_arbiter #(
   parameter int unsigned ADDR_W       = 16,
   parameter int unsigned LINE_W       = 128,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_address,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,

   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_address,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,

   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int unsigned      CNT_W      = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_I = 2'd1,
      SERVE_D = 2'd2,
      DONE    = 2'd3
   } state_e;

   state_e            state_q,       state_d;
   logic [CNT_W-1:0]  starve_cnt_q,  starve_cnt_d;
   logic [ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [LINE_W-1:0] mem_wdata_q,   mem_wdata_d;
   logic              op_write_q,    op_write_d;

   logic d_req;
   logic grant_i;
   logic grant_d;

   // State and transaction latches
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         starve_cnt_q  <= '0;
         mem_address_q <= '0;
         mem_wdata_q   <= '0;
         op_write_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         starve_cnt_q  <= starve_cnt_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
         op_write_q    <= op_write_d;
      end
   end

   // Arbitration decision, only acted on in IDLE
   always_comb begin
      d_req   = d_read | d_write;
      grant_i = 1'b0;
      grant_d = 1'b0;
      if (i_read && d_req) begin
         if (starve_cnt_q == STARVE_MAX) grant_i = 1'b1;
         else                            grant_d = 1'b1;
      end else if (i_read) begin
         grant_i = 1'b1;
      end else if (d_req) begin
         grant_d = 1'b1;
      end
   end

   // Next state, latches and memory/response strobes
   always_comb begin
      state_d       = state_q;
      starve_cnt_d  = starve_cnt_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;
      op_write_d    = op_write_q;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      i_resp        = 1'b0;
      d_resp        = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_i) begin
               state_d       = SERVE_I;
               starve_cnt_d  = '0;
               mem_address_d = i_address;
               op_write_d    = 1'b0;
            end else if (grant_d) begin
               state_d       = SERVE_D;
               mem_address_d = d_address;
               mem_wdata_d   = d_wdata;
               // Write wins if both ops are raised together
               op_write_d    = d_write;
               if (i_read) starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
         end
         SERVE_I: begin
            mem_read = 1'b1;
            if (mem_resp) begin
               i_resp  = 1'b1;
               state_d = DONE;
            end
         end
         SERVE_D: begin
            mem_read  = ~op_write_q;
            mem_write = op_write_q;
            if (mem_resp) begin
               d_resp  = 1'b1;
               state_d = DONE;
            end
         end
         DONE: begin
            // Gap cycle so a finished requester can drop its request
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;
   assign i_rdata     = mem_rdata;
   assign d_rdata     = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: lone requests, contention order,
// request held through DONE, reset mid-transaction, illegal read+write with stray mem_resp.
module tb_mem_arbiter;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned LINE_W = 128;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              i_read = 1'b0;
   logic [ADDR_W-1:0] i_address = '0;
   logic [LINE_W-1:0] i_rdata;
   logic              i_resp;
   logic              d_read = 1'b0;
   logic              d_write = 1'b0;
   logic [ADDR_W-1:0] d_address = '0;
   logic [LINE_W-1:0] d_wdata = '0;
   logic [LINE_W-1:0] d_rdata;
   logic              d_resp;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_address;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata = '0;
   logic              mem_resp = 1'b0;

   int checks = 0;
   int errors = 0;

   localparam logic [LINE_W-1:0] RDATA_I = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
   localparam logic [LINE_W-1:0] WDATA_A = 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5;
   localparam logic [LINE_W-1:0] WDATA_B = 128'h01234567_89ABCDEF_01234567_89ABCDEF;
   localparam logic [LINE_W-1:0] WDATA_C = 128'hFFFFFFFF_00000000_FFFFFFFF_00000000;

   mem_arbiter dut (
      .clk         (clk),
      .rst         (rst),
      .i_read      (i_read),
      .i_address   (i_address),
      .i_rdata     (i_rdata),
      .i_resp      (i_resp),
      .d_read      (d_read),
      .d_write     (d_write),
      .d_address   (d_address),
      .d_wdata     (d_wdata),
      .d_rdata     (d_rdata),
      .d_resp      (d_resp),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_resp    (mem_resp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic [11:0] grant_i_pat;
      logic        gi;
      grant_i_pat = 12'b0010_0001_0000;

      // Reset
      repeat (2) @(negedge clk);
      #1;
      chk("rst_mem_read",  mem_read,    0);
      chk("rst_mem_write", mem_write,   0);
      chk("rst_i_resp",    i_resp,      0);
      chk("rst_d_resp",    d_resp,      0);
      chk("rst_addr",      mem_address, 0);
      chk("rst_wdata",     mem_wdata,   0);
      chk("rst_starve",    dut.starve_cnt_q, 0);
      @(negedge clk); rst = 1'b0;

      // Lone I-read, memory answers in cycle 3
      @(negedge clk); i_read = 1'b1; i_address = 16'h1230; #1;
      chk("t1_c0_idle_rd", mem_read, 0);
      @(negedge clk); #1;
      chk("t1_c1_rd",    mem_read,    1);
      chk("t1_c1_wr",    mem_write,   0);
      chk("t1_c1_addr",  mem_address, 16'h1230);
      chk("t1_c1_iresp", i_resp,      0);
      @(negedge clk); #1;
      chk("t1_c2_rd",    mem_read,    1);
      chk("t1_c2_addr",  mem_address, 16'h1230);
      @(negedge clk); mem_resp = 1'b1; mem_rdata = RDATA_I; #1;
      chk("t1_c3_rd",    mem_read,    1);
      chk("t1_c3_addr",  mem_address, 16'h1230);
      chk("t1_c3_iresp", i_resp,      1);
      chk("t1_c3_rdata", i_rdata,     RDATA_I);
      chk("t1_c3_dresp", d_resp,      0);
      @(negedge clk); mem_resp = 1'b0; i_read = 1'b0; #1;
      chk("t1_c4_rd",    mem_read,  0);
      chk("t1_c4_wr",    mem_write, 0);
      chk("t1_c4_iresp", i_resp,    0);
      @(negedge clk); #1;
      chk("t1_c5_idle_rd", mem_read, 0);

      // Lone D-write, memory answers in cycle 2
      @(negedge clk); d_write = 1'b1; d_address = 16'h4000; d_wdata = WDATA_A; #1;
      chk("t2_c0_wr", mem_write, 0);
      @(negedge clk); #1;
      chk("t2_c1_wr",    mem_write,   1);
      chk("t2_c1_rd",    mem_read,    0);
      chk("t2_c1_addr",  mem_address, 16'h4000);
      chk("t2_c1_wdata", mem_wdata,   WDATA_A);
      chk("t2_c1_dresp", d_resp,      0);
      @(negedge clk); mem_resp = 1'b1; #1;
      chk("t2_c2_wr",    mem_write, 1);
      chk("t2_c2_dresp", d_resp,    1);
      chk("t2_c2_iresp", i_resp,    0);
      @(negedge clk); mem_resp = 1'b0; d_write = 1'b0; #1;
      chk("t2_c3_dresp", d_resp,    0);
      chk("t2_c3_wr",    mem_write, 0);
      @(negedge clk); #1;
      chk("t2_c4_dresp", d_resp,    0);
      chk("t2_c4_wr",    mem_write, 0);

      // Contention with 1-cycle memory: D,D,D,D,I,D,D,D,D,I,D,D
      i_read = 1'b1; d_read = 1'b1; i_address = 16'h1111; d_address = 16'h2222;
      mem_resp = 1'b1; mem_rdata = WDATA_C;
      for (int k = 0; k < 12; k++) begin
         gi = grant_i_pat[k];
         @(negedge clk); #1;
         chk($sformatf("t3_g%0d_rd", k),    mem_read,    1);
         chk($sformatf("t3_g%0d_wr", k),    mem_write,   0);
         chk($sformatf("t3_g%0d_addr", k),  mem_address, gi ? 16'h1111 : 16'h2222);
         chk($sformatf("t3_g%0d_iresp", k), i_resp,      gi ? 1 : 0);
         chk($sformatf("t3_g%0d_dresp", k), d_resp,      gi ? 0 : 1);
         @(negedge clk); #1;
         chk($sformatf("t3_g%0d_done_rd", k), mem_read, 0);
         @(negedge clk);
         if (k == 11) begin
            i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
         end
      end
      #1;
      chk("t3_starve_end", dut.starve_cnt_q, 2);

      // D-read held one cycle into DONE must not be re-granted
      @(negedge clk); d_read = 1'b1; d_address = 16'h3000;
      @(negedge clk); mem_resp = 1'b1; #1;
      chk("t4_c1_rd",    mem_read,    1);
      chk("t4_c1_addr",  mem_address, 16'h3000);
      chk("t4_c1_dresp", d_resp,      1);
      @(negedge clk); mem_resp = 1'b0; #1;
      chk("t4_c2_rd",    mem_read, 0);
      chk("t4_c2_dresp", d_resp,   0);
      @(negedge clk); d_read = 1'b0; #1;
      chk("t4_c3_rd", mem_read, 0);
      @(negedge clk); #1;
      chk("t4_c4_rd", mem_read, 0);
      d_read = 1'b1;
      @(negedge clk); #1;
      chk("t4_c5_rd",   mem_read,    1);
      chk("t4_c5_addr", mem_address, 16'h3000);

      // Reset during SERVE_D; memory response arrives afterwards
      @(negedge clk); rst = 1'b1; #1;
      chk("t5_c6_dresp", d_resp, 0);
      chk("t5_c6_starve_pre", dut.starve_cnt_q, 2);
      @(negedge clk); mem_resp = 1'b1; #1;
      chk("t5_c7_rd",     mem_read,    0);
      chk("t5_c7_wr",     mem_write,   0);
      chk("t5_c7_dresp",  d_resp,      0);
      chk("t5_c7_iresp",  i_resp,      0);
      chk("t5_c7_starve", dut.starve_cnt_q, 0);
      chk("t5_c7_addr",   mem_address, 0);
      chk("t5_c7_wdata",  mem_wdata,   0);
      @(negedge clk); rst = 1'b0; d_read = 1'b0; mem_resp = 1'b0; #1;
      chk("t5_c8_rd",    mem_read, 0);
      chk("t5_c8_dresp", d_resp,   0);

      // Illegal read+write together, with a stray mem_resp in IDLE
      @(negedge clk);
      mem_resp = 1'b1; d_read = 1'b1; d_write = 1'b1;
      d_address = 16'h5550; d_wdata = WDATA_B; #1;
      chk("t6_c0_iresp", i_resp,    0);
      chk("t6_c0_dresp", d_resp,    0);
      chk("t6_c0_wr",    mem_write, 0);
      @(negedge clk); mem_resp = 1'b0; d_address = 16'h7777; d_wdata = WDATA_C; #1;
      chk("t6_c1_wr",    mem_write,   1);
      chk("t6_c1_rd",    mem_read,    0);
      chk("t6_c1_addr",  mem_address, 16'h5550);
      chk("t6_c1_wdata", mem_wdata,   WDATA_B);
      @(negedge clk); mem_resp = 1'b1; #1;
      chk("t6_c2_wr",    mem_write, 1);
      chk("t6_c2_rd",    mem_read,  0);
      chk("t6_c2_dresp", d_resp,    1);
      @(negedge clk); mem_resp = 1'b0; d_read = 1'b0; d_write = 1'b0; #1;
      chk("t6_c3_wr",    mem_write, 0);
      chk("t6_c3_rd",    mem_read,  0);
      chk("t6_c3_dresp", d_resp,    0);
      @(negedge clk); #1;
      chk("t6_c4_wr", mem_write, 0);
      chk("t6_c4_rd", mem_read,  0);
      @(negedge clk); #1;
      chk("t6_c5_wr", mem_write, 0);
      chk("t6_c5_rd", mem_read,  0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single physical-memory port between the instruction-cache miss path and the data-cache miss/writeback path of the pipelined LC-3b core. Holds a grant for the full duration of one memory transaction and routes the response back to the granted requester. Uses fixed data-side priority with a bounded-starvation override for the instruction side. Sits between the two L1 caches and main memory (or L2).

## Interface
Parameters:
- ADDR_W, 16, address width (lc3b_word)
- LINE_W, 128, cache-line width in bits
- STARVE_LIMIT, 4, number of consecutive contested D-grants after which I wins the next contested arbitration; must be ≥1

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- i_read  in  1  I-cache line-read request; held until i_resp
- i_address  in  ADDR_W  I-cache line address
- i_rdata  out  LINE_W  read data to I-cache, valid while i_resp=1
- i_resp  out  1  I-cache transaction complete, one cycle
- d_read  in  1  D-cache line-read request; held until d_resp
- d_write  in  1  D-cache line-write request; held until d_resp
- d_address  in  ADDR_W  D-cache line address
- d_wdata  in  LINE_W  D-cache write data
- d_rdata  out  LINE_W  read data to D-cache, valid while d_resp=1
- d_resp  out  1  D-cache transaction complete, one cycle
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- mem_address  out  ADDR_W  memory address
- mem_wdata  out  LINE_W  memory write data
- mem_rdata  in  LINE_W  memory read data
- mem_resp  in  1  memory transaction complete

## Operation
- States: IDLE, SERVE_I, SERVE_D, DONE. Encoded state register plus starve_cnt register, width clog2(STARVE_LIMIT+1).
- IDLE: d_req = d_read|d_write.
  - Only i_read: go SERVE_I.
  - Only d_req: go SERVE_D; starve_cnt unchanged.
  - Both: if starve_cnt == STARVE_LIMIT go SERVE_I, else go SERVE_D and starve_cnt += 1.
  - Neither: stay.
  - On every transition into SERVE_I, starve_cnt ← 0.
  - On the grant edge, register mem_address ← granted address and mem_wdata ← d_wdata (D grant) or unchanged (I grant). Register op: d_write has precedence if d_read and d_write are both high (illegal input; write performed, read dropped).
- SERVE_I: mem_read=1, mem_write=0. On mem_resp: i_resp=1 combinationally the same cycle; next state DONE.
- SERVE_D: mem_read=~latched_write, mem_write=latched_write. On mem_resp: d_resp=1 the same cycle; next state DONE.
- DONE: mem strobes 0, both resp 0, requests ignored; next state IDLE unconditionally. This gives requesters one cycle to drop their request so it is not re-granted.
- i_rdata and d_rdata are continuously driven from mem_rdata. They are only meaningful while the matching resp is high.
- mem_resp in IDLE or DONE is ignored. No resp is generated.
- Requests that change while in SERVE_x do not affect the latched address, wdata or op.

## Timing
- Reset (rst=1 at edge): state ← IDLE, starve_cnt ← 0, mem_address ← 0, mem_wdata ← 0, latched op ← read. Outputs after reset: mem_read=0, mem_write=0, i_resp=0, d_resp=0.
- Reset mid-transaction abandons the transaction. No resp is issued for it, and strobes are low from the following cycle.
- Latency, with a request first high in IDLE at cycle 0:
  - Strobe asserted at cycle 1.
  - Earliest resp at cycle 1, if mem_resp=1 then.
  - DONE at resp+1.
  - IDLE at resp+2.
  - Earliest next grant strobe at resp+3.
- Memory strobes are held for the full SERVE_x state. Memory may take any number of cycles (≥1).
- Simultaneous requests in IDLE are resolved per the rule above within one cycle. There is no partial or preemptive grant.

## Test plan
- Lone I-read: i_read=1, i_address=0x1230, memory responds after 3 cycles with 0xDEAD…BEEF.
  - Required: mem_read=1 with mem_address=0x1230 in cycles 1–3.
  - i_resp=1 with i_rdata=0xDEAD…BEEF in cycle 3.
  - d_resp stays 0.
  - Strobes are 0 in cycle 4.
- Lone D-write: d_write=1, d_address=0x4000, d_wdata=0xA5A5…, mem_resp after 2 cycles.
  - Required: mem_write=1, mem_read=0, and the matching address/data.
  - d_resp pulses exactly one cycle.
- Contention: i_read and d_read both held high continuously, STARVE_LIMIT=4, 1-cycle memory.
  - Required grant order: D,D,D,D,I,D,D,D,D,I.
  - Each response goes only to the granted side.
- Requester holds its request through DONE: d_read kept high one cycle after d_resp.
  - Required: no second mem_read is issued until d_read is sampled high in IDLE.
- Reset mid-operation: assert rst during SERVE_D with mem_resp pending.
  - Required: next cycle mem_read=mem_write=0, d_resp never pulses, starve_cnt=0, mem_address=0.
- Illegal d_read & d_write both high, plus a stray mem_resp in IDLE.
  - Required: a single write transaction is performed.
  - The stray mem_resp produces no i_resp or d_resp.
